// File: rtl/hazard_pkg.sv
// Shared types, forward-select encodings and the register-match helper for the hazard controller.
package hazard_pkg;

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    MUL_WAIT = 1'b1
  } hz_state_t;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  // r0 is hardwired to zero, so it can never carry a true dependency.
  function automatic logic regMatch(input logic [4:0] a, input logic [4:0] b);
    return (a != 5'd0) && (a == b);
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Stage-observation and pipeline-control bundle between the core datapath (master)
// and the hazard controller (slave).
interface hazard_ctrl_if;
  import hazard_pkg::*;

  logic [4:0] RsAddrD;
  logic [4:0] RtAddrD;
  logic [4:0] RsAddrE;
  logic [4:0] RtAddrE;
  logic [4:0] RAddrE;
  logic       RegWriteE;
  logic       MemReadE;
  logic       MULOpE;
  logic       BranchTaken;
  logic [4:0] RAddrM;
  logic       RegWriteM;
  logic [4:0] RAddrW;
  logic       RegWriteW;

  logic       StallF;
  logic       StallD;
  logic       StallE;
  logic       FlushD;
  logic       FlushE;
  logic       FlushM;
  logic [1:0] ForwardA;
  logic [1:0] ForwardB;
  logic       Busy;

  modport master (
    output RsAddrD, RtAddrD, RsAddrE, RtAddrE, RAddrE, RegWriteE, MemReadE,
           MULOpE, BranchTaken, RAddrM, RegWriteM, RAddrW, RegWriteW,
    input  StallF, StallD, StallE, FlushD, FlushE, FlushM, ForwardA, ForwardB, Busy
  );

  modport slave (
    input  RsAddrD, RtAddrD, RsAddrE, RtAddrE, RAddrE, RegWriteE, MemReadE,
           MULOpE, BranchTaken, RAddrM, RegWriteM, RAddrW, RegWriteW,
    output StallF, StallD, StallE, FlushD, FlushE, FlushM, ForwardA, ForwardB, Busy
  );

endinterface

// File: rtl/hazard_fwd.sv
// Operand forward-select compare: picks the youngest in-flight writer (M before W)
// for each E-stage source register.
module hazard_fwd
  import hazard_pkg::*;
(
  input  logic [4:0] RsAddrE,
  input  logic [4:0] RtAddrE,
  input  logic [4:0] RAddrM,
  input  logic       RegWriteM,
  input  logic [4:0] RAddrW,
  input  logic       RegWriteW,
  output logic [1:0] ForwardA,
  output logic [1:0] ForwardB
);

  logic [4:0] srcAddr [2];
  logic [1:0] fwdSel  [2];

  assign srcAddr[0] = RsAddrE;
  assign srcAddr[1] = RtAddrE;

  for (genvar gi = 0; gi < 2; gi++) begin : gOperand
    logic hitM;
    logic hitW;

    assign hitM = RegWriteM && regMatch(RAddrM, srcAddr[gi]);
    assign hitW = RegWriteW && regMatch(RAddrW, srcAddr[gi]);

    assign fwdSel[gi] = hitM ? FWD_MEM :
                        hitW ? FWD_WB  : FWD_REG;
  end

  assign ForwardA = fwdSel[0];
  assign ForwardB = fwdSel[1];

endmodule

// File: rtl/hazard_ctrl.sv
// Five-stage pipeline hazard controller: load-use and RAW stalls, taken-branch flushes,
// multi-cycle multiply hold. Build option: HAZARD_FWD_EN enables operand forwarding.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MUL_LAT = 4
) (
  input  logic          Clock,
  input  logic          Reset,
  hazard_ctrl_if.slave  hz
);

  localparam int              CNT_W       = $clog2(MUL_LAT) + 1;
  localparam bit              MUL_HOLD_EN = (MUL_LAT > 1);
  localparam logic [CNT_W-1:0] CNT_LOAD   = MUL_HOLD_EN ? CNT_W'(MUL_LAT - 2) : '0;

  localparam logic [0:0] ST_RUN      = RUN;
  localparam logic [0:0] ST_MUL_WAIT = MUL_WAIT;

  logic [0:0]       stateReg;
  logic [0:0]       stateNext;
  logic [CNT_W-1:0] mulCntReg;
  logic [CNT_W-1:0] mulCntNext;

  logic inWait;
  logic mulStart;
  logic loadUse;
  logic rawStall;

  logic stallF;
  logic stallD;
  logic stallE;
  logic flushD;
  logic flushE;
  logic flushM;
  logic [1:0] fwdA;
  logic [1:0] fwdB;

  assign inWait   = (stateReg == ST_MUL_WAIT);
  assign mulStart = !inWait && hz.MULOpE && MUL_HOLD_EN && !hz.BranchTaken;

  // ---------------------------------------------------------------------------
  // D-stage dependency detection
  // ---------------------------------------------------------------------------
  logic [4:0] depAddr [2];
  logic [1:0] loadHit;
  logic [1:0] rawHit;

  assign depAddr[0] = hz.RsAddrD;
  assign depAddr[1] = hz.RtAddrD;

  for (genvar gi = 0; gi < 2; gi++) begin : gDepSrc
    assign loadHit[gi] = hz.MemReadE && regMatch(hz.RAddrE, depAddr[gi]);
    assign rawHit[gi]  = (hz.RegWriteE && regMatch(hz.RAddrE, depAddr[gi])) ||
                         (hz.RegWriteM && regMatch(hz.RAddrM, depAddr[gi])) ||
                         (hz.RegWriteW && regMatch(hz.RAddrW, depAddr[gi]));
  end

  assign loadUse = |loadHit;

`ifdef HAZARD_FWD_EN
  // Forwarding covers every RAW case except a load still in E.
  assign rawStall = 1'b0;

  hazard_fwd u_fwd (
    .RsAddrE   (hz.RsAddrE),
    .RtAddrE   (hz.RtAddrE),
    .RAddrM    (hz.RAddrM),
    .RegWriteM (hz.RegWriteM),
    .RAddrW    (hz.RAddrW),
    .RegWriteW (hz.RegWriteW),
    .ForwardA  (fwdA),
    .ForwardB  (fwdB)
  );
`else
  // Without bypass paths the reader waits in D until the writer has left W.
  assign rawStall = |rawHit;
  assign fwdA     = FWD_REG;
  assign fwdB     = FWD_REG;
`endif

  // ---------------------------------------------------------------------------
  // Control outputs: Reset > branch > multiply hold > load-use / RAW
  // ---------------------------------------------------------------------------
  always_comb begin
    stallF = 1'b0;
    stallD = 1'b0;
    stallE = 1'b0;
    flushD = 1'b0;
    flushE = 1'b0;
    flushM = 1'b0;
    if (Reset) begin
      stallF = 1'b0;
    end else if (hz.BranchTaken) begin
      flushD = 1'b1;
      flushE = 1'b1;
    end else if (inWait || mulStart) begin
      stallF = 1'b1;
      stallD = 1'b1;
      stallE = 1'b1;
      flushM = 1'b1;
    end else if (loadUse || rawStall) begin
      stallF = 1'b1;
      stallD = 1'b1;
      flushE = 1'b1;
    end
  end

  assign hz.StallF   = stallF;
  assign hz.StallD   = stallD;
  assign hz.StallE   = stallE;
  assign hz.FlushD   = flushD;
  assign hz.FlushE   = flushE;
  assign hz.FlushM   = flushM;
  assign hz.ForwardA = Reset ? FWD_REG : fwdA;
  assign hz.ForwardB = Reset ? FWD_REG : fwdB;
  assign hz.Busy     = inWait && !Reset;

  // ---------------------------------------------------------------------------
  // Multiply hold sequencing: entry cycle plus MUL_LAT-1 wait cycles
  // ---------------------------------------------------------------------------
  always_comb begin
    stateNext  = stateReg;
    mulCntNext = mulCntReg;
    if (inWait) begin
      if (mulCntReg == '0) begin
        stateNext = ST_RUN;
      end else begin
        mulCntNext = mulCntReg - CNT_W'(1);
      end
    end else if (mulStart) begin
      stateNext  = ST_MUL_WAIT;
      mulCntNext = CNT_LOAD;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      stateReg  <= ST_RUN;
      mulCntReg <= '0;
    end else begin
      stateReg  <= stateNext;
      mulCntReg <= mulCntNext;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: two instances (MUL_LAT=4 and MUL_LAT=1) driven with
// directed and random stage contents, checked against a rule-level reference model.
`timescale 1ns/1ps
module tb_hazard_ctrl;

  typedef struct packed {
    logic       rst;
    logic [4:0] rsD;
    logic [4:0] rtD;
    logic [4:0] rsE;
    logic [4:0] rtE;
    logic [4:0] rE;
    logic       regWrE;
    logic       memRdE;
    logic       mulE;
    logic       br;
    logic [4:0] rM;
    logic       regWrM;
    logic [4:0] rW;
    logic       regWrW;
  } stim_t;

  logic Clock = 1'b0;
  logic Reset;
  always #5 Clock = ~Clock;

  hazard_ctrl_if hz4 ();
  hazard_ctrl_if hz1 ();

  hazard_ctrl #(.MUL_LAT(4)) dut4 (.Clock(Clock), .Reset(Reset), .hz(hz4.slave));
  hazard_ctrl #(.MUL_LAT(1)) dut1 (.Clock(Clock), .Reset(Reset), .hz(hz1.slave));

  logic [10:0] q4 [$];
  logic [10:0] q1 [$];
  int w4 = 0;
  int w1 = 0;
  int checks = 0;
  int errors = 0;
  int txn = 0;

  // ---------------- reference model ----------------
  function automatic logic hit(input logic [4:0] a, input logic [4:0] b);
    return (a != 5'd0) && (a == b);
  endfunction

  function automatic logic [1:0] fwdRef(input logic [4:0] x, input stim_t s);
    logic [1:0] r;
    r = 2'b00;
    if (s.regWrM && hit(s.rM, x))      r = 2'b01;
    else if (s.regWrW && hit(s.rW, x)) r = 2'b10;
`ifndef HAZARD_FWD_EN
    r = 2'b00;
`endif
    return r;
  endfunction

  function automatic logic dep(input logic [4:0] x, input stim_t s);
    return (s.regWrE && hit(s.rE, x)) || (s.regWrM && hit(s.rM, x)) ||
           (s.regWrW && hit(s.rW, x));
  endfunction

  // waitLeft = wait cycles still owed after the multiply entry cycle
  function automatic logic [10:0] expected(input stim_t s, input int lat, input int waitLeft);
    logic sF, sD, sE, fD, fE, fM, busy, loadUse, raw;
    {sF, sD, sE, fD, fE, fM} = 6'b0;
    if (s.rst) return 11'b0;
    busy    = (waitLeft > 0);
    loadUse = s.memRdE && (hit(s.rE, s.rsD) || hit(s.rE, s.rtD));
    raw     = dep(s.rsD, s) || dep(s.rtD, s);
`ifdef HAZARD_FWD_EN
    raw = 1'b0;
`endif
    if (s.br) begin
      fD = 1'b1; fE = 1'b1;
    end else if (busy || (s.mulE && lat > 1)) begin
      sF = 1'b1; sD = 1'b1; sE = 1'b1; fM = 1'b1;
    end else if (loadUse || raw) begin
      sF = 1'b1; sD = 1'b1; fE = 1'b1;
    end
    return {sF, sD, sE, fD, fE, fM, fwdRef(s.rsE, s), fwdRef(s.rtE, s), busy};
  endfunction

  function automatic int nextWait(input stim_t s, input int lat, input int waitLeft);
    if (s.rst) return 0;
    if (waitLeft > 0) return waitLeft - 1;
    if (s.mulE && lat > 1 && !s.br) return lat - 1;
    return 0;
  endfunction

  // ---------------- stimulus ----------------
  `define SET_IF(h) \
    h.RsAddrD = s.rsD; h.RtAddrD = s.rtD; h.RsAddrE = s.rsE; h.RtAddrE = s.rtE; \
    h.RAddrE = s.rE; h.RegWriteE = s.regWrE; h.MemReadE = s.memRdE; h.MULOpE = s.mulE; \
    h.BranchTaken = s.br; h.RAddrM = s.rM; h.RegWriteM = s.regWrM; h.RAddrW = s.rW; \
    h.RegWriteW = s.regWrW;

  task automatic drive(input stim_t s);
    Reset = s.rst;
    `SET_IF(hz4)
    `SET_IF(hz1)
  endtask

  task automatic step(input stim_t s);
    @(posedge Clock);
    #1;
    drive(s);
    q4.push_back(expected(s, 4, w4));
    q1.push_back(expected(s, 1, w1));
    w4 = nextWait(s, 4, w4);
    w1 = nextWait(s, 1, w1);
  endtask

  function automatic stim_t idle();
    stim_t s;
    s = '0;
    return s;
  endfunction

  // ---------------- monitor ----------------
  task automatic compare(input string name, input logic [10:0] act, input logic [10:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s txn %0d outputs(sF sD sE fD fE fM fA fB busy) act=%b exp=%b",
               name, txn, act, exp);
    end else begin
      $display("txn %0d %s out=%b ok", txn, name, act);
    end
  endtask

  initial begin
    forever begin
      @(negedge Clock);
      if (q4.size() > 0) begin
        compare("lat4", {hz4.StallF, hz4.StallD, hz4.StallE, hz4.FlushD, hz4.FlushE,
                         hz4.FlushM, hz4.ForwardA, hz4.ForwardB, hz4.Busy}, q4.pop_front());
      end
      if (q1.size() > 0) begin
        compare("lat1", {hz1.StallF, hz1.StallD, hz1.StallE, hz1.FlushD, hz1.FlushE,
                         hz1.FlushM, hz1.ForwardA, hz1.ForwardB, hz1.Busy}, q1.pop_front());
      end
      txn++;
    end
  end

  // ---------------- test sequence ----------------
  initial begin
    stim_t s;
    s = idle();
    s.rst = 1'b1;
    drive(s);
    repeat (2) step(s);

    // load r5 in E, consumer reads r5 as Rt; then the load moves to M
    s = idle(); s.memRdE = 1'b1; s.regWrE = 1'b1; s.rE = 5'd5; s.rtD = 5'd5;
    step(s);
    s = idle(); s.rM = 5'd5; s.regWrM = 1'b1; s.rsE = 5'd0; s.rtE = 5'd5; s.rtD = 5'd9;
    step(s);
    step(idle());
    // same load, consumer uses r0: never a hazard
    s = idle(); s.memRdE = 1'b1; s.regWrE = 1'b1; s.rE = 5'd0; s.rtD = 5'd0;
    step(s);

    // taken branch while a load-use condition holds
    s = idle(); s.memRdE = 1'b1; s.regWrE = 1'b1; s.rE = 5'd6; s.rsD = 5'd6; s.br = 1'b1;
    step(s);
    step(idle());

    // multiply held in E for the full latency, then released
    s = idle(); s.mulE = 1'b1; s.rE = 5'd2; s.regWrE = 1'b1;
    repeat (4) step(s);
    repeat (2) step(idle());

    // forwarding priority: M before W, then W alone
    s = idle(); s.rsE = 5'd7; s.rM = 5'd7; s.regWrM = 1'b1; s.rW = 5'd7; s.regWrW = 1'b1;
    step(s);
    s.regWrM = 1'b0;
    step(s);
    s.rtE = 5'd7;
    step(s);

    // reset on the second MUL_WAIT cycle, then a fresh full hold
    s = idle(); s.mulE = 1'b1;
    repeat (2) step(s);
    s.rst = 1'b1;
    step(s);
    step(idle());
    s = idle(); s.mulE = 1'b1;
    repeat (4) step(s);
    step(idle());

    // ADD r3 followed by a dependent ADD: writer walks E -> M -> W -> gone
    s = idle(); s.rsD = 5'd3; s.rE = 5'd3; s.regWrE = 1'b1;
    step(s);
    s = idle(); s.rsD = 5'd3; s.rM = 5'd3; s.regWrM = 1'b1;
    step(s);
    s = idle(); s.rsD = 5'd3; s.rW = 5'd3; s.regWrW = 1'b1;
    step(s);
    s = idle(); s.rsD = 5'd3;
    step(s);

    // random traffic over a small register window to make matches common
    for (int i = 0; i < 300; i++) begin
      s.rst    = ($urandom_range(0, 39) == 0);
      s.rsD    = 5'($urandom_range(0, 7));
      s.rtD    = 5'($urandom_range(0, 7));
      s.rsE    = 5'($urandom_range(0, 7));
      s.rtE    = 5'($urandom_range(0, 7));
      s.rE     = 5'($urandom_range(0, 7));
      s.regWrE = 1'($urandom_range(0, 1));
      s.memRdE = ($urandom_range(0, 3) == 0);
      s.mulE   = ($urandom_range(0, 7) == 0);
      s.br     = ($urandom_range(0, 7) == 0);
      s.rM     = 5'($urandom_range(0, 7));
      s.regWrM = 1'($urandom_range(0, 1));
      s.rW     = 5'($urandom_range(0, 7));
      s.regWrW = 1'($urandom_range(0, 1));
      step(s);
    end

    repeat (3) @(posedge Clock);
    if (q4.size() + q1.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain left=%0d required=0", q4.size() + q1.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
